// File: rtl/ifft8_stage_if.sv
// ifft8_stage_if: streaming handshake bundle for the 8-point IFFT first stage.
//   in_valid/in_ready/in_data    : sample input (producer -> stage)
//   out_valid/out_ready/out_data : result output (stage -> consumer)
//   out_index                    : position 0..7 of the current result
//   out_last                     : marks the result at out_index 7
// Complex packing on both data buses: real [2*DW-1:DW], imag [DW-1:0].
// The slave modport is the stage side; the master modport is the environment side.
interface ifft8_stage_if #(
  parameter int DW = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] out_data;
  logic [2:0]      out_index;
  logic            out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/ifft8_stage.sv
// ifft8_stage: first stage of an 8-point radix-2 DIF inverse FFT.
// Loads 8 complex samples serially, runs 4 butterflies (one per cycle) using
// conjugate twiddles W8^-k, then streams the 8 results out with backpressure.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ifft8_stage_if.slave (input stream, output stream, index, last)
//   busy : high while computing or emitting results
// All outputs are registered.
module ifft8_stage #(
  parameter int DW   = 32,
  parameter int FRAC = 16
) (
  input  logic           clk,
  input  logic           rst,
  ifft8_stage_if.slave   bus,
  output logic           busy
);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_OUTPUT  = 2'd2
  } state_t;

  // Twiddle (cos, sin) of W8^-k in Q16.16, packed {cos, sin} and sign-extended to DW.
  function automatic logic [2*DW-1:0] twiddle(input logic [1:0] k);
    logic signed [31:0] c;
    logic signed [31:0] s;
    case (k)
      2'd0: begin c = 32'sh0001_0000; s = 32'sh0000_0000; end
      2'd1: begin c = 32'sh0000_B504; s = 32'sh0000_B504; end
      2'd2: begin c = 32'sh0000_0000; s = 32'sh0001_0000; end
      2'd3: begin c = 32'shFFFF_4AFC; s = 32'sh0000_B504; end
      default: begin c = 32'sh0001_0000; s = 32'sh0000_0000; end
    endcase
    return {DW'(c), DW'(s)};
  endfunction

  // Fixed-point complex multiply (a+jb)(c+jd); full 2*DW precision, then
  // arithmetic shift by FRAC and truncation to DW (no rounding/saturation).
  function automatic logic [2*DW-1:0] cmul(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b,
    input logic signed [DW-1:0] c,
    input logic signed [DW-1:0] d
  );
    logic signed [2*DW-1:0] ae, be, ce, de, re_w, im_w;
    ae   = (2*DW)'(a);
    be   = (2*DW)'(b);
    ce   = (2*DW)'(c);
    de   = (2*DW)'(d);
    re_w = ae * ce - be * de;
    im_w = ae * de + be * ce;
    return {re_w[DW+FRAC-1:FRAC], im_w[DW+FRAC-1:FRAC]};
  endfunction

  state_t                state_r;
  logic [2:0]            cnt_r;
  logic signed [DW-1:0]  x_re_r [8];
  logic signed [DW-1:0]  x_im_r [8];
  logic signed [DW-1:0]  y_re_r [8];
  logic signed [DW-1:0]  y_im_r [8];

  logic                  in_ready_r;
  logic                  out_valid_r;
  logic [2*DW-1:0]       out_data_r;
  logic [2:0]            out_index_r;
  logic                  out_last_r;
  logic                  busy_r;

  logic [1:0]            k_s;
  logic signed [DW-1:0]  sum_re_s, sum_im_s;
  logic signed [DW-1:0]  diff_re_s, diff_im_s;
  logic signed [DW-1:0]  tw_c_s, tw_s_s;
  logic signed [DW-1:0]  prod_re_s, prod_im_s;
  logic [2:0]            idx_next_s;

  // Butterfly datapath for pair (k, k+4) selected by the compute counter.
  always_comb begin
    k_s        = cnt_r[1:0];
    sum_re_s   = x_re_r[{1'b0, k_s}] + x_re_r[{1'b1, k_s}];
    sum_im_s   = x_im_r[{1'b0, k_s}] + x_im_r[{1'b1, k_s}];
    diff_re_s  = x_re_r[{1'b0, k_s}] - x_re_r[{1'b1, k_s}];
    diff_im_s  = x_im_r[{1'b0, k_s}] - x_im_r[{1'b1, k_s}];
    {tw_c_s, tw_s_s}       = twiddle(k_s);
    {prod_re_s, prod_im_s} = cmul(diff_re_s, diff_im_s, tw_c_s, tw_s_s);
    idx_next_s = out_index_r + 3'd1;
  end

  // Control FSM, sample/result storage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_LOAD;
      cnt_r       <= 3'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= {(2*DW){1'b0}};
      out_index_r <= 3'd0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        x_re_r[i] <= {DW{1'b0}};
        x_im_r[i] <= {DW{1'b0}};
        y_re_r[i] <= {DW{1'b0}};
        y_im_r[i] <= {DW{1'b0}};
      end
    end else begin
      case (state_r)
        S_LOAD: begin
          if (bus.in_valid && in_ready_r) begin
            x_re_r[cnt_r] <= bus.in_data[2*DW-1:DW];
            x_im_r[cnt_r] <= bus.in_data[DW-1:0];
            if (cnt_r == 3'd7) begin
              state_r    <= S_COMPUTE;
              cnt_r      <= 3'd0;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b1;
            end else begin
              cnt_r <= cnt_r + 3'd1;
            end
          end
        end
        S_COMPUTE: begin
          y_re_r[{1'b0, k_s}] <= sum_re_s;
          y_im_r[{1'b0, k_s}] <= sum_im_s;
          y_re_r[{1'b1, k_s}] <= prod_re_s;
          y_im_r[{1'b1, k_s}] <= prod_im_s;
          if (cnt_r == 3'd3) begin
            // y[0] was written at k=0, so it can be presented right away.
            state_r     <= S_OUTPUT;
            cnt_r       <= 3'd0;
            out_valid_r <= 1'b1;
            out_data_r  <= {y_re_r[0], y_im_r[0]};
            out_index_r <= 3'd0;
            out_last_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
        S_OUTPUT: begin
          if (out_ready_ok()) begin
            if (out_index_r == 3'd7) begin
              state_r     <= S_LOAD;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              out_index_r <= 3'd0;
              out_data_r  <= {(2*DW){1'b0}};
              busy_r      <= 1'b0;
              in_ready_r  <= 1'b1;
            end else begin
              out_index_r <= idx_next_s;
              out_data_r  <= {y_re_r[idx_next_s], y_im_r[idx_next_s]};
              out_last_r  <= (idx_next_s == 3'd7);
            end
          end
        end
        default: begin
          state_r     <= S_LOAD;
          cnt_r       <= 3'd0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          out_index_r <= 3'd0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Output handshake completes this cycle.
  function automatic logic out_ready_ok();
    return out_valid_r && bus.out_ready;
  endfunction

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_index = out_index_r;
  assign bus.out_last  = out_last_r;
  assign busy          = busy_r;

endmodule
